// File: rtl/sha1_sched_mc_if.sv
// Handshake/data bundle between the message source and the SHA-1 schedule generator.
// With SHA1_SCHED_SHA0_EN defined the bundle also carries the sha0 select.
interface sha1_sched_mc_if #(
   parameter int CHANNELS = 1
);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic          start;
   logic [31:0]   din;
`ifdef SHA1_SCHED_SHA0_EN
   logic          sha0;
`endif
   logic [31:0]   w_out;
   logic          w_valid;
   logic [6:0]    round;
   logic [1:0]    phase;
   logic [CW-1:0] chan;
   logic          load;
   logic          busy;
   logic          done;

   modport master (
`ifdef SHA1_SCHED_SHA0_EN
      output sha0,
`endif
      output start, din,
      input  w_out, w_valid, round, phase, chan, load, busy, done
   );

   modport slave (
`ifdef SHA1_SCHED_SHA0_EN
      input  sha0,
`endif
      input  start, din,
      output w_out, w_valid, round, phase, chan, load, busy, done
   );
endinterface

// File: rtl/sha1_sched_mc.sv
// Multi-channel SHA-1 message schedule and round-control generator, one slot per clock.
// Define SHA1_SCHED_SHA0_EN to add the sha0 select (expansion without rotl1).
module sha1_sched_mc #(
   parameter int CHANNELS  = 1,
   parameter int PHASE_LEN = 20
) (
   input  logic           clk,
   input  logic           rst_n,
   sha1_sched_mc_if.slave bus
);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int HD = 16 * CHANNELS;
   localparam int R  = 4 * PHASE_LEN;

   localparam logic [6:0]    P1     = 7'(PHASE_LEN);
   localparam logic [6:0]    P2     = 7'(2 * PHASE_LEN);
   localparam logic [6:0]    P3     = 7'(3 * PHASE_LEN);
   localparam logic [6:0]    T_LAST = 7'(R - 1);
   localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

   state_t              state_reg;
   logic [6:0]          t_reg;
   logic [CW-1:0]       c_reg;
   logic [HD-1:0][31:0] hist_reg;

   logic [31:0] mix;
   logic [31:0] w_next;
   logic [1:0]  phase_next;
   logic        chan_last;
   logic        use_rotl;

`ifdef SHA1_SCHED_SHA0_EN
   logic sha0_reg;
   assign use_rotl = ~sha0_reg;
`else
   assign use_rotl = 1'b1;
`endif

   // hist_reg[d-1] holds the word emitted d slots ago; d = n*CHANNELS stays in one channel.
   always_comb begin
      mix = hist_reg[3*CHANNELS-1] ^ hist_reg[8*CHANNELS-1] ^
            hist_reg[14*CHANNELS-1] ^ hist_reg[16*CHANNELS-1];
      if (state_reg == LOAD)
         w_next = bus.din;
      else if (use_rotl)
         w_next = {mix[30:0], mix[31]};
      else
         w_next = mix;

      if (t_reg >= P3)
         phase_next = 2'd3;
      else if (t_reg >= P2)
         phase_next = 2'd2;
      else if (t_reg >= P1)
         phase_next = 2'd1;
      else
         phase_next = 2'd0;

      chan_last = (c_reg == C_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         t_reg       <= '0;
         c_reg       <= '0;
         hist_reg    <= '0;
`ifdef SHA1_SCHED_SHA0_EN
         sha0_reg    <= 1'b0;
`endif
         bus.w_out   <= '0;
         bus.w_valid <= 1'b0;
         bus.round   <= '0;
         bus.phase   <= '0;
         bus.chan    <= '0;
         bus.load    <= 1'b0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               bus.w_valid <= 1'b0;
               bus.done    <= 1'b0;
               if (bus.start) begin
                  state_reg <= LOAD;
                  t_reg     <= '0;
                  c_reg     <= '0;
                  bus.busy  <= 1'b1;
`ifdef SHA1_SCHED_SHA0_EN
                  sha0_reg  <= bus.sha0;
`endif
               end
            end
            LOAD, EXPAND: begin
               bus.w_out   <= w_next;
               bus.w_valid <= 1'b1;
               bus.round   <= t_reg;
               bus.phase   <= phase_next;
               bus.chan    <= c_reg;
               bus.load    <= (state_reg == LOAD);
               bus.done    <= 1'b0;
               hist_reg    <= {hist_reg[HD-2:0], w_next};

               if (chan_last) begin
                  c_reg <= '0;
                  t_reg <= t_reg + 7'd1;
               end else begin
                  c_reg <= c_reg + CW'(1);
               end

               if (chan_last && state_reg == LOAD && t_reg == 7'd15)
                  state_reg <= EXPAND;

               // Final slot: busy drops together with the last valid word.
               if (chan_last && state_reg == EXPAND && t_reg == T_LAST) begin
                  state_reg <= IDLE;
                  t_reg     <= '0;
                  bus.busy  <= 1'b0;
                  bus.done  <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/sha1_sched_mc.md
Name: sha1_sched_mc

Overview:
- Parametrised multi-channel SHA-1 message-schedule and round-control generator.
- Accepts 16 message words per channel for up to CHANNELS interleaved blocks.
- Emits the expanded word W[t] with round number, phase and channel tags, one slot per clock.
- Feeds the round datapath in place of a single-channel fixed-80-round control generator.

Parameters:
- CHANNELS, 1, interleaved independent blocks (1..8); slot k serves channel k % CHANNELS, round k / CHANNELS.
- PHASE_LEN, 20, rounds per phase; total rounds R = 4*PHASE_LEN; legal range 5..31.
- CW (localparam), max(1,$clog2(CHANNELS)), channel tag width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a block group; sampled only when busy==0.
- din  in  32  message word; sampled on the 16*CHANNELS edges after start is accepted.
- sha0  in  1  SHA-0 select (only with optional feature); sampled with start.
- w_out  out  32  expanded schedule word W[t] for the current slot.
- w_valid  out  1  w_out and tags valid.
- round  out  7  t, 0..R-1.
- phase  out  2  t / PHASE_LEN.
- chan  out  CW  channel of the current slot.
- load  out  1  high while t<16 (w_out is pass-through din).
- busy  out  1  block group in progress.
- done  out  1  one-cycle pulse with the last slot.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; slot counter and history registers cleared. Reset mid-block aborts with no done pulse.
- States:
  - IDLE: busy=0.
  - LOAD: slots k < 16*CHANNELS.
  - EXPAND: remaining slots.
- Start: IDLE & start at edge E0 -> LOAD, k=0, sha0 latched.
- Slot k (1-cycle registered latency): at edge E(k+1), w_out/round/phase/chan/load are updated for slot k and w_valid=1, with t=k/CHANNELS.
  - LOAD (t<16): w_out = din sampled at E(k+1).
  - EXPAND (t>=16): w_out = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]) of the same channel.
- History: shift register of depth 16*CHANNELS holding every emitted w_out. Taps at 3*CHANNELS, 8*CHANNELS, 14*CHANNELS and 16*CHANNELS slots back, so channels never mix.
- Transitions: LOAD -> EXPAND after slot 16*CHANNELS-1; EXPAND -> IDLE after slot R*CHANNELS-1.
- At the final edge: busy falls, last w_valid rises, done=1. The next edge clears w_valid and done.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted at the next edge, leaving exactly one w_valid=0 cycle between groups.
- start while busy: ignored, no effect.
- din outside LOAD: ignored.
- Counters: k wraps only via the IDLE transition; round never exceeds R-1; phase saturates at 3 by construction.

Optional Feature:
- Macro: SHA1_SCHED_SHA0_EN.
- Defined: sha0 port exists. When the latched sha0=1, expansion omits rotl1 (SHA-0); when 0, SHA-1.
- Undefined: sha0 port absent; SHA-1 expansion only; logic identical to the sha0=0 case.

Test Plan:
- "abc" block, CHANNELS=1, din W0=0x61626380, W1..W14=0, W15=0x00000018 -> W16=0xC2C4C700, W17=0x00000000, W18=0x00000030; 80 valid slots; phase changes at rounds 20/40/60; done coincident with round=79.
- CHANNELS=2, channel 0 = "abc" words, channel 1 = all zero -> chan alternates 0/1; channel 0 W16=0xC2C4C700; channel 1 all outputs 0; 160 slots; done on slot 159 with chan=1.
- start held high across a group -> second group begins exactly 2 edges after done (one idle w_valid=0 cycle); start pulses while busy cause no restart.
- rst_n driven low at slot 40 -> all outputs 0 immediately (asynchronous); after release, a fresh "abc" run matches the first scenario bit-exactly.
- PHASE_LEN=5 -> 20 rounds, phase steps every 5 rounds, done at round 19.
- SHA1_SCHED_SHA0_EN defined, sha0=1, "abc" -> W16=0x61626380, W18=0x00000018; with sha0=0 -> matches the first scenario.
